piso_serializer: RTL and testbench



---
 rtl/ser_pkg.sv | 18 +
 rtl/bit_tick_gen.sv | 30 +++
 rtl/piso_serializer.sv | 90 +++++++++
 tb/tb_piso_serializer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/ser_pkg.sv
// Shared types and default sizing for the serializer and its downstream
// 4-bit serial-in shift register.
package ser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

  localparam int SER_WIDTH = 4;
  localparam int SER_DIV   = 1;

  // Counter width that stays at least one bit even for a divide-by-one.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period clock-enable divider: marks the first and last cycle of each
// serial bit period while enabled; restart realigns to a fresh period.
module bit_tick_gen
  import ser_pkg::*;
#(
  parameter int DIV = SER_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic restart,
  output logic per_start,
  output logic per_end
);

  localparam int            CW   = cnt_w(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] div_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  div_cnt <= '0;
    else if (restart || !en || div_cnt == LAST) div_cnt <= '0;
    else                                      div_cnt <= div_cnt + CW'(1);
  end

  assign per_start = en && (div_cnt == '0);
  assign per_end   = en && (div_cnt == LAST);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with valid/ready input and a divided
// bit rate; back-to-back words stream with no idle bit between them.
module piso_serializer
  import ser_pkg::*;
#(
  parameter int WIDTH     = SER_WIDTH,
  parameter int DIV       = SER_DIV,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             out,
  output logic             out_valid,
  output logic             bit_stb,
  output logic             busy,
  output logic             done
);

  localparam int            BW    = $clog2(WIDTH);
  localparam logic [BW-1:0] LASTB = BW'(WIDTH - 1);

  ser_state_e       state, state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bit_cnt;
  logic             done_q;
  logic             per_start, per_end, word_end, accept;

  assign busy = (state == SHIFT);

  bit_tick_gen #(.DIV(DIV)) u_tick (
    .clk       (clk),
    .rst       (rst),
    .en        (busy),
    .restart   (accept),
    .per_start (per_start),
    .per_end   (per_end)
  );

  assign word_end = per_end && (bit_cnt == LASTB);
  assign accept   = din_valid && din_ready;

  // Ready opens only in IDLE and on the final cycle of a word, so a held
  // din_valid can never reload the word already being shifted.
  always_comb begin
    state_nxt = state;
    din_ready = 1'b0;
    case (state)
      IDLE: begin
        din_ready = 1'b1;
        if (din_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        din_ready = word_end;
        if (word_end && !din_valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= word_end;
      if (accept) begin
        shreg   <= din;
        bit_cnt <= '0;
      end else if (per_end) begin
        shreg   <= MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
        bit_cnt <= word_end ? '0 : bit_cnt + BW'(1);
      end
    end
  end

  assign out       = busy && (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]);
  assign out_valid = busy;
  assign bit_stb   = per_start;
  assign done      = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: a DIV=1 MSB-first unit (looped into a 4-bit
// serial-in register) and a DIV=3 LSB-first unit, against a cycle-position model.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] din0 = '0, din1 = '0;
  logic       v0 = 1'b0, v1 = 1'b0;
  logic       rdy0, out0, ov0, stb0, busy0, done0;
  logic       rdy1, out1, ov1, stb1, busy1, done1;
  logic [3:0] ds;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(4), .DIV(1), .MSB_FIRST(1'b1)) u0 (
    .clk(clk), .rst(rst), .din(din0), .din_valid(v0), .din_ready(rdy0),
    .out(out0), .out_valid(ov0), .bit_stb(stb0), .busy(busy0), .done(done0)
  );

  piso_serializer #(.WIDTH(4), .DIV(3), .MSB_FIRST(1'b0)) u1 (
    .clk(clk), .rst(rst), .din(din1), .din_valid(v1), .din_ready(rdy1),
    .out(out1), .out_valid(ov1), .bit_stb(stb1), .busy(busy1), .done(done1)
  );

  // Downstream 4-bit serial-in shift register fed by unit 0.
  always @(posedge clk or posedge rst) begin
    if (rst) ds <= '0;
    else     ds <= {ds[2:0], out0};
  end

  // Model: a word occupies 4*div cycles; m_pos is the cycle offset within
  // the word being sent, -1 when nothing is being sent.
  int         m_div [2] = '{1, 3};
  bit         m_msb [2] = '{1'b1, 1'b0};
  logic [3:0] m_word[2];
  int         m_pos [2] = '{-1, -1};
  logic       m_done[2] = '{1'b0, 1'b0};

  function automatic logic exp_out(input int u);
    int i;
    if (m_pos[u] < 0) return 1'b0;
    i = m_pos[u] / m_div[u];
    if (m_msb[u]) i = 3 - i;
    return m_word[u][i];
  endfunction

  function automatic logic exp_ready(input int u);
    return (m_pos[u] < 0) || (m_pos[u] == 4 * m_div[u] - 1);
  endfunction

  function automatic logic exp_stb(input int u);
    return (m_pos[u] >= 0) && (m_pos[u] % m_div[u] == 0);
  endfunction

  task automatic model_step(input int u, input logic acc, input logic [3:0] d);
    logic last;
    last = (m_pos[u] == 4 * m_div[u] - 1);
    m_done[u] = last;
    if (acc) begin
      m_word[u] = d;
      m_pos[u]  = 0;
    end else if (m_pos[u] >= 0) begin
      m_pos[u] = last ? -1 : m_pos[u] + 1;
    end
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_pos[u]  = -1;
      m_done[u] = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input int u, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s u%0d observed=%h expected=%h t=%0t", tag, u, obs, exp, $time);
    end
  endtask

  task automatic check_unit(input int u, input logic rdy, input logic o, input logic ov,
                            input logic stb, input logic bsy, input logic dn);
    chk("din_ready", u, 4'(rdy), 4'(exp_ready(u)));
    chk("out",       u, 4'(o),   4'(exp_out(u)));
    chk("out_valid", u, 4'(ov),  4'(m_pos[u] >= 0));
    chk("bit_stb",   u, 4'(stb), 4'(exp_stb(u)));
    chk("busy",      u, 4'(bsy), 4'(m_pos[u] >= 0));
    chk("done",      u, 4'(dn),  4'(m_done[u]));
  endtask

  // One clock: check both units mid-cycle, drive unit u, then step the model.
  task automatic cyc(input int u, input logic v, input logic [3:0] d);
    logic a0, a1;
    @(negedge clk);
    check_unit(0, rdy0, out0, ov0, stb0, busy0, done0);
    check_unit(1, rdy1, out1, ov1, stb1, busy1, done1);
    if (u == 0) begin v0 = v; din0 = d; end
    else        begin v1 = v; din1 = d; end
    a0 = v0 && exp_ready(0);
    a1 = v1 && exp_ready(1);
    @(posedge clk);
    model_step(0, a0, din0);
    model_step(1, a1, din1);
  endtask

  // Asynchronous reset raised between edges; outputs must clear at once.
  task automatic do_reset();
    v0 = 1'b0;
    v1 = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_out",   0, 4'(out0),  4'h0); chk("rst_out",   1, 4'(out1),  4'h0);
    chk("rst_ov",    0, 4'(ov0),   4'h0); chk("rst_ov",    1, 4'(ov1),   4'h0);
    chk("rst_busy",  0, 4'(busy0), 4'h0); chk("rst_busy",  1, 4'(busy1), 4'h0);
    chk("rst_ready", 0, 4'(rdy0),  4'h1); chk("rst_ready", 1, 4'(rdy1),  4'h1);
    chk("rst_done",  0, 4'(done0), 4'h0); chk("rst_done",  1, 4'(done1), 4'h0);
    chk("rst_stb",   0, 4'(stb0),  4'h0); chk("rst_stb",   1, 4'(stb1),  4'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    repeat (2) cyc(0, 1'b0, 4'h0);

    // single word, MSB first, DIV=1
    cyc(0, 1'b1, 4'b1011);
    repeat (6) cyc(0, 1'b0, 4'h0);

    // back-to-back with din_valid held
    cyc(0, 1'b1, 4'b1011);
    repeat (4) cyc(0, 1'b1, 4'b0110);
    repeat (6) cyc(0, 1'b0, 4'h0);

    // DIV=3 unit, LSB first
    cyc(1, 1'b1, 4'b1001);
    repeat (14) cyc(1, 1'b0, 4'h0);
    cyc(1, 1'b1, 4'b0011);
    repeat (11) cyc(1, 1'b1, 4'b1100);
    repeat (14) cyc(1, 1'b0, 4'h0);

    // words offered while busy are ignored
    cyc(0, 1'b1, 4'b1011);
    repeat (3) cyc(0, 1'b1, 4'b0000);
    repeat (4) cyc(0, 1'b0, 4'h0);

    // abort mid-word on both units: no done afterwards
    cyc(0, 1'b1, 4'b1110);
    cyc(1, 1'b1, 4'b0111);
    do_reset();
    repeat (4) cyc(0, 1'b0, 4'h0);

    // loopback into the downstream register
    cyc(0, 1'b1, 4'b1101);
    repeat (4) cyc(0, 1'b0, 4'h0);
    #1;
    chk("loop_q",    0, ds,        4'b1101);
    chk("loop_sout", 0, 4'(ds[3]), 4'h1);
    repeat (3) cyc(0, 1'b0, 4'h0);

    // randomized traffic on both units with occasional resets
    for (int blk = 0; blk < 60; blk++) begin
      int u;
      int n;
      u = int'($urandom_range(0, 1));
      n = int'($urandom_range(1, 12));
      for (int k = 0; k < n; k++)
        cyc(u, $urandom_range(0, 3) != 0, 4'($urandom));
      if ($urandom_range(0, 14) == 0) do_reset();
    end
    v0 = 1'b0;
    v1 = 1'b0;
    repeat (16) cyc(0, 1'b0, 4'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
